// File: rtl/image_channel_streamer.sv
// Streams planar multi-channel image words from a one-cycle-latency read memory
// into per-channel core inputs, switching channels round-robin on back-pressure.
module image_channel_streamer #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int N_ROWS     = 28,
    parameter int N_COLS     = 28,
    parameter int N_CHANNELS = 3
) (
    input  logic                                   system_clock,
    input  logic                                   global_reset,
    input  logic                                   enable_i,
    input  logic                                   start_i,
    input  logic [N_CHANNELS-1:0]                  hold_data_i,
    input  logic [DATA_WIDTH-1:0]                  rd_data_i,
    output logic [ADDR_WIDTH-1:0]                  rd_addr_o,
    output logic [N_CHANNELS-1:0][DATA_WIDTH-1:0]  data_o,
    output logic [N_CHANNELS-1:0]                  data_valid_o,
    output logic                                   busy_o,
    output logic                                   done_o
);

    localparam int TOTAL = N_ROWS * N_COLS;
    localparam int PTR_W = $clog2(TOTAL + 1);
    localparam int CH_W  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_STREAM = 3'd3,
        S_WAIT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                 state_r;
    logic [PTR_W-1:0]       ptr_r [N_CHANNELS];
    logic [N_CHANNELS-1:0]  loaded_r;
    logic [N_CHANNELS-1:0]  finished_r;
    logic [CH_W-1:0]        curr_r;

    logic [PTR_W-1:0]       curr_ptr_s;
    logic                   xfer_s;
    logic                   take_s;
    logic [PTR_W-1:0]       look_s;
    logic [PTR_W-1:0]       offset_s;
    logic [N_CHANNELS-1:0]  curr_onehot_s;
    logic [CH_W:0]          hold_pick_s;
    logic [CH_W:0]          fin_pick_s;

    // Search order starts after 'from' and wraps, so 'from' itself is tried last.
    function automatic logic [CH_W:0] next_unfinished(
        input logic [N_CHANNELS-1:0] fin,
        input logic [CH_W-1:0]       from
    );
        logic            found;
        logic [CH_W-1:0] sel;
        logic [CH_W-1:0] cand;
        found = 1'b0;
        sel   = from;
        for (int k = 1; k <= N_CHANNELS; k++) begin
            cand = CH_W'((int'(from) + k) % N_CHANNELS);
            if (!found && !fin[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        return {found, sel};
    endfunction

    // Memory address with one-word lookahead on a transfer, clamped inside the plane.
    always_comb begin
        curr_ptr_s = ptr_r[curr_r];
        xfer_s     = (state_r == S_STREAM) && enable_i && data_valid_o[curr_r]
                     && !hold_data_i[curr_r];
        take_s     = xfer_s && (curr_ptr_s < PTR_W'(TOTAL));
        look_s     = curr_ptr_s + PTR_W'(take_s);
        if (look_s > PTR_W'(TOTAL - 1)) begin
            offset_s = PTR_W'(TOTAL - 1);
        end else begin
            offset_s = look_s;
        end
        rd_addr_o = ADDR_WIDTH'(curr_r) * ADDR_WIDTH'(TOTAL) + ADDR_WIDTH'(offset_s);
    end

    // Round-robin candidates for a hold-driven switch and for a finished channel.
    always_comb begin
        curr_onehot_s = {{(N_CHANNELS-1){1'b0}}, 1'b1} << curr_r;
        hold_pick_s   = next_unfinished(finished_r, curr_r);
        fin_pick_s    = next_unfinished(finished_r | curr_onehot_s, curr_r);
    end

    // Frame sequencer with per-channel read pointers and registered outputs.
    always_ff @(posedge system_clock or posedge global_reset) begin
        if (global_reset) begin
            state_r      <= S_IDLE;
            loaded_r     <= '0;
            finished_r   <= '0;
            curr_r       <= '0;
            data_o       <= '0;
            data_valid_o <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            for (int c = 0; c < N_CHANNELS; c++) begin
                ptr_r[c] <= '0;
            end
        end else if (enable_i) begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        loaded_r   <= '0;
                        finished_r <= '0;
                        curr_r     <= '0;
                        busy_o     <= 1'b1;
                        done_o     <= 1'b0;
                        state_r    <= S_FETCH;
                        for (int c = 0; c < N_CHANNELS; c++) begin
                            ptr_r[c] <= '0;
                        end
                    end
                end
                S_FETCH: begin
                    if (loaded_r[curr_r]) begin
                        data_valid_o[curr_r] <= 1'b1;
                        state_r              <= S_STREAM;
                    end else begin
                        state_r <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    data_o[curr_r]   <= rd_data_i;
                    ptr_r[curr_r]    <= curr_ptr_s + PTR_W'(1);
                    loaded_r[curr_r] <= 1'b1;
                    state_r          <= S_FETCH;
                end
                S_STREAM: begin
                    if (hold_data_i[curr_r]) begin
                        // The offered word stays in data_o as the pending word.
                        data_valid_o[curr_r] <= 1'b0;
                        if (hold_pick_s[CH_W]) begin
                            curr_r <= hold_pick_s[CH_W-1:0];
                        end
                        state_r <= S_WAIT;
                    end else if (curr_ptr_s < PTR_W'(TOTAL)) begin
                        data_o[curr_r] <= rd_data_i;
                        ptr_r[curr_r]  <= curr_ptr_s + PTR_W'(1);
                    end else begin
                        data_valid_o[curr_r] <= 1'b0;
                        finished_r[curr_r]   <= 1'b1;
                        if (fin_pick_s[CH_W]) begin
                            curr_r  <= fin_pick_s[CH_W-1:0];
                            state_r <= S_FETCH;
                        end else begin
                            busy_o  <= 1'b0;
                            done_o  <= 1'b1;
                            state_r <= S_DONE;
                        end
                    end
                end
                S_WAIT: begin
                    if (!hold_data_i[curr_r]) begin
                        state_r <= S_FETCH;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_channel_streamer.sv
// Randomized self-checking bench: per-channel in-order scoreboard against a memory
// image, plus directed timing checks for start, hold switching, freeze and reset.
module tb_image_channel_streamer;

    localparam int AW     = 16;
    localparam int DW     = 32;
    localparam int NR     = 2;
    localparam int NC     = 2;
    localparam int NCH    = 3;
    localparam int TOTAL  = NR * NC;
    localparam int NWORDS = NCH * TOTAL;

    logic                     system_clock = 1'b0;
    logic                     global_reset;
    logic                     enable_i;
    logic                     start_i;
    logic [NCH-1:0]           hold_data_i;
    logic [DW-1:0]            rd_data_i;
    logic [AW-1:0]            rd_addr_o;
    logic [NCH-1:0][DW-1:0]   data_o;
    logic [NCH-1:0]           data_valid_o;
    logic                     busy_o;
    logic                     done_o;

    image_channel_streamer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_ROWS(NR), .N_COLS(NC), .N_CHANNELS(NCH)
    ) dut (
        .system_clock(system_clock),
        .global_reset(global_reset),
        .enable_i(enable_i),
        .start_i(start_i),
        .hold_data_i(hold_data_i),
        .rd_data_i(rd_data_i),
        .rd_addr_o(rd_addr_o),
        .data_o(data_o),
        .data_valid_o(data_valid_o),
        .busy_o(busy_o),
        .done_o(done_o)
    );

    always #5 system_clock = ~system_clock;

    logic [DW-1:0] mem [NWORDS];

    always @(posedge system_clock) begin
        if (rd_addr_o < AW'(NWORDS)) rd_data_i <= mem[rd_addr_o];
        else                         rd_data_i <= 'x;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_xfer_cyc = 0;
    int exp_idx [NCH];
    logic [DW-1:0] xfer_log [$];
    int            xfer_cyc [$];

    task automatic fill_mem_identity();
        for (int a = 0; a < NWORDS; a++) mem[a] = DW'(a);
    endtask

    task automatic fill_mem_random();
        for (int a = 0; a < NWORDS; a++) mem[a] = $urandom;
    endtask

    // One clock: check invariants, apply inputs, score transfers at the coming edge.
    task automatic cycle(input logic en, input logic [NCH-1:0] h);
        n_tests++;
        if (rd_addr_o > AW'(NWORDS - 1)) begin
            n_fail++;
            $display("FAIL addr_range: rd_addr_o=%0d max=%0d", rd_addr_o, NWORDS - 1);
        end
        n_tests++;
        if ($countones(data_valid_o) > 1) begin
            n_fail++;
            $display("FAIL valid_onehot: data_valid_o=%b expected at most one bit", data_valid_o);
        end
        enable_i    = en;
        hold_data_i = h;
        for (int c = 0; c < NCH; c++) begin
            if (data_valid_o[c] && !h[c] && en) begin
                n_tests++;
                if (exp_idx[c] >= TOTAL) begin
                    n_fail++;
                    $display("FAIL xfer_extra: ch%0d got %0h after all %0d words", c, data_o[c], TOTAL);
                end else if (data_o[c] !== mem[c*TOTAL + exp_idx[c]]) begin
                    n_fail++;
                    $display("FAIL xfer_data: ch%0d word %0d got %0h expected %0h",
                             c, exp_idx[c], data_o[c], mem[c*TOTAL + exp_idx[c]]);
                end
                exp_idx[c]++;
                last_xfer_cyc = cyc + 1;
                xfer_log.push_back(data_o[c]);
                xfer_cyc.push_back(cyc);
            end
        end
        @(posedge system_clock);
        @(negedge system_clock);
        cyc++;
    endtask

    task automatic pulse_start();
        for (int c = 0; c < NCH; c++) exp_idx[c] = 0;
        start_i = 1'b1;
        cycle(1'b1, '0);
        start_i = 1'b0;
    endtask

    task automatic wait_valid(input int c, input logic [NCH-1:0] h, input int budget);
        int n;
        n = 0;
        while (!data_valid_o[c] && n < budget) begin
            cycle(1'b1, h);
            n++;
        end
        n_tests++;
        if (!data_valid_o[c]) begin
            n_fail++;
            $display("FAIL wait_valid_timeout: ch%0d valid=%b expected 1 within %0d cycles", c, data_valid_o[c], budget);
        end
    endtask

    task automatic stream_n(input int c, input int n, input logic [NCH-1:0] h, input int budget);
        int target;
        int k;
        target = exp_idx[c] + n;
        k = 0;
        while (exp_idx[c] < target && k < budget) begin
            cycle(1'b1, h);
            k++;
        end
        n_tests++;
        if (exp_idx[c] < target) begin
            n_fail++;
            $display("FAIL stream_timeout: ch%0d words=%0d expected %0d", c, exp_idx[c], target);
        end
    endtask

    task automatic run_to_done(input int hold_pct, input int en_pct, input int budget);
        int k;
        logic [NCH-1:0] h;
        logic en;
        k = 0;
        while (!done_o && k < budget) begin
            for (int c = 0; c < NCH; c++) h[c] = ($urandom_range(0, 99) < hold_pct);
            en = ($urandom_range(0, 99) < en_pct);
            cycle(en, h);
            k++;
        end
        n_tests++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_end: done=%b busy=%b expected done=1 busy=0", done_o, busy_o);
        end
        n_tests++;
        if (data_valid_o !== '0) begin
            n_fail++;
            $display("FAIL frame_end_valid: data_valid_o=%b expected 0", data_valid_o);
        end
        for (int c = 0; c < NCH; c++) begin
            n_tests++;
            if (exp_idx[c] != TOTAL) begin
                n_fail++;
                $display("FAIL frame_count: ch%0d delivered %0d expected %0d", c, exp_idx[c], TOTAL);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_tests++;
        if (data_o !== '0 || data_valid_o !== '0 || busy_o !== 1'b0 || done_o !== 1'b0 || rd_addr_o !== '0) begin
            n_fail++;
            $display("FAIL %s: data_o=%0h valid=%b busy=%b done=%b addr=%0d expected all 0",
                     tag, data_o, data_valid_o, busy_o, done_o, rd_addr_o);
        end
    endtask

    task automatic test_reset();
        global_reset = 1'b1;
        enable_i = 1'b1;
        start_i = 1'b0;
        hold_data_i = '0;
        repeat (2) @(negedge system_clock);
        check_reset_values("reset_state");
        global_reset = 1'b0;
        @(negedge system_clock);
        check_reset_values("idle_after_reset");
    endtask

    task automatic test_basic();
        fill_mem_identity();
        xfer_log.delete();
        xfer_cyc.delete();
        pulse_start();
        n_tests++;
        if (busy_o !== 1'b1 || data_valid_o[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL start_cycle1: busy=%b valid0=%b expected 1/0", busy_o, data_valid_o[0]);
        end
        cycle(1'b1, '0);
        cycle(1'b1, '0);
        n_tests++;
        if (data_valid_o[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL start_cycle3: valid0=%b expected 0", data_valid_o[0]);
        end
        cycle(1'b1, '0);
        n_tests++;
        if (data_valid_o[0] !== 1'b1 || data_o[0] !== mem[0]) begin
            n_fail++;
            $display("FAIL start_cycle4: valid0=%b data0=%0h expected 1/%0h", data_valid_o[0], data_o[0], mem[0]);
        end
        run_to_done(0, 100, 200);
        n_tests++;
        if (cyc != last_xfer_cyc) begin
            n_fail++;
            $display("FAIL done_timing: done seen at cycle %0d expected %0d", cyc, last_xfer_cyc);
        end
        n_tests++;
        if (rd_addr_o !== AW'(NWORDS - 1)) begin
            n_fail++;
            $display("FAIL last_addr: rd_addr_o=%0d expected %0d", rd_addr_o, NWORDS - 1);
        end
        n_tests++;
        if (xfer_log.size() != NWORDS) begin
            n_fail++;
            $display("FAIL order_len: %0d words expected %0d", xfer_log.size(), NWORDS);
        end else begin
            for (int i = 0; i < NWORDS; i++) begin
                n_tests++;
                if (xfer_log[i] !== DW'(i)) begin
                    n_fail++;
                    $display("FAIL order: position %0d got %0h expected %0h", i, xfer_log[i], i);
                end
                if (i % TOTAL != 0) begin
                    n_tests++;
                    if (xfer_cyc[i] - xfer_cyc[i-1] != 1) begin
                        n_fail++;
                        $display("FAIL rate: word %0d gap %0d cycles expected 1", i, xfer_cyc[i] - xfer_cyc[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_hold_switch();
        int n;
        fill_mem_identity();
        pulse_start();
        wait_valid(0, 3'b000, 10);
        stream_n(0, 2, 3'b000, 10);
        cycle(1'b1, 3'b001);
        n_tests++;
        if (data_valid_o[0] !== 1'b0 || data_o[0] !== mem[2]) begin
            n_fail++;
            $display("FAIL hold_drop: valid0=%b data0=%0h expected 0/%0h", data_valid_o[0], data_o[0], mem[2]);
        end
        n = 1;
        while (!data_valid_o[1] && n < 10) begin
            cycle(1'b1, 3'b001);
            n++;
        end
        n_tests++;
        if (n != 5) begin
            n_fail++;
            $display("FAIL switch_latency: ch1 valid after %0d cycles expected 5", n);
        end
        stream_n(1, 2, 3'b001, 10);
        cycle(1'b1, 3'b011);
        wait_valid(2, 3'b011, 12);
        stream_n(2, TOTAL, 3'b010, 20);
        wait_valid(0, 3'b010, 10);
        n_tests++;
        if (data_o[0] !== mem[2]) begin
            n_fail++;
            $display("FAIL resume_word: data0=%0h expected %0h", data_o[0], mem[2]);
        end
        run_to_done(0, 100, 100);
    endtask

    task automatic test_wait_release();
        int n;
        logic stray;
        fill_mem_random();
        pulse_start();
        wait_valid(0, 3'b000, 10);
        stream_n(0, 1, 3'b000, 5);
        cycle(1'b1, 3'b001);
        wait_valid(1, 3'b001, 10);
        stream_n(1, 1, 3'b001, 5);
        cycle(1'b1, 3'b011);
        wait_valid(2, 3'b011, 10);
        stream_n(2, 1, 3'b011, 5);
        cycle(1'b1, 3'b110);
        wait_valid(0, 3'b110, 10);
        stream_n(0, 1, 3'b110, 5);
        cycle(1'b1, 3'b111);
        stray = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (data_valid_o !== '0) stray = 1'b1;
            cycle(1'b1, 3'b111);
        end
        n_tests++;
        if (stray || data_valid_o !== '0) begin
            n_fail++;
            $display("FAIL wait_release_hold: valid=%b seen while held, expected none", data_valid_o);
        end
        n = 0;
        while (!data_valid_o[1] && n < 6) begin
            cycle(1'b1, 3'b101);
            n++;
        end
        n_tests++;
        if (!data_valid_o[1] || n > 3) begin
            n_fail++;
            $display("FAIL release_latency: ch1 valid=%b after %0d cycles expected 1 within 3", data_valid_o[1], n);
        end
        run_to_done(0, 100, 200);
    endtask

    task automatic test_enable_freeze();
        logic [NCH-1:0][DW-1:0] snap_d;
        logic [NCH-1:0]         snap_v;
        logic [AW-1:0]          snap_a;
        fill_mem_random();
        pulse_start();
        wait_valid(0, 3'b000, 10);
        stream_n(0, 2, 3'b000, 10);
        snap_d = data_o;
        snap_v = data_valid_o;
        snap_a = '0;
        for (int i = 0; i < 5; i++) begin
            enable_i = 1'b0;
            hold_data_i = '0;
            #1;
            if (i == 0) begin
                snap_a = rd_addr_o;
            end else begin
                n_tests++;
                if (rd_addr_o !== snap_a) begin
                    n_fail++;
                    $display("FAIL freeze_addr: rd_addr_o=%0d expected %0d", rd_addr_o, snap_a);
                end
            end
            @(posedge system_clock);
            @(negedge system_clock);
            cyc++;
            n_tests++;
            if (data_o !== snap_d || data_valid_o !== snap_v) begin
                n_fail++;
                $display("FAIL freeze_out: data_o=%0h valid=%b expected %0h/%b", data_o, data_valid_o, snap_d, snap_v);
            end
        end
        run_to_done(0, 100, 100);
    endtask

    task automatic test_reset_mid();
        int k;
        fill_mem_identity();
        pulse_start();
        k = 0;
        while ((exp_idx[0] + exp_idx[1] + exp_idx[2]) < 6 && k < 50) begin
            cycle(1'b1, '0);
            k++;
        end
        #2;
        global_reset = 1'b1;
        #1;
        check_reset_values("mid_frame_reset");
        @(negedge system_clock);
        global_reset = 1'b0;
        @(negedge system_clock);
        pulse_start();
        wait_valid(0, 3'b000, 10);
        n_tests++;
        if (data_o[0] !== mem[0]) begin
            n_fail++;
            $display("FAIL replay_after_reset: data0=%0h expected %0h", data_o[0], mem[0]);
        end
        run_to_done(0, 100, 100);
    endtask

    task automatic test_start_busy();
        fill_mem_random();
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            start_i = (i % 2 == 0);
            cycle(1'b1, '0);
        end
        start_i = 1'b0;
        run_to_done(0, 100, 100);
        pulse_start();
        n_tests++;
        if (done_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_from_done: done=%b busy=%b expected 0/1", done_o, busy_o);
        end
        wait_valid(0, 3'b000, 10);
        n_tests++;
        if (data_o[0] !== mem[0]) begin
            n_fail++;
            $display("FAIL restart_word0: data0=%0h expected %0h", data_o[0], mem[0]);
        end
        run_to_done(0, 100, 100);
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            fill_mem_random();
            pulse_start();
            run_to_done(30, 85, 2000);
        end
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) exp_idx[c] = 0;
        test_reset();
        test_basic();
        test_hold_switch();
        test_wait_release();
        test_enable_freeze();
        test_reset_mid();
        test_start_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
